fft_out_serializer: RTL and testbench
=====================================

Name: fft_out_serializer

Overview:
- Output-side reader for the 16-point FFT butterfly pipeline.
- Accepts one full frame of 16 complex 17-bit samples in parallel, as produced by the final butterfly stage, under a valid/ready handshake.
- Streams the frame out one complex sample per cycle under a valid/ready handshake, in natural or bit-reversed index order, with optional rounded down-scaling.
- Sits between the last butterfly stage and the downstream serial consumer (DMA / magnitude block).

Parameters:
- DW, 17: sample width, two's complement, real and imaginary.
- BITREV, 0: 0 = output index k reads slot k; 1 = output index k reads slot bitrev4(k).
- SHIFT, 0: arithmetic right shift applied at output, 0..4; round half-up when SHIFT>0.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  parallel frame present on data_iK_*.
- in_ready  output  1  block can capture a frame this cycle.
- data_iK_R, K=0..15  input  DW each  real part of slot K.
- data_iK_I, K=0..15  input  DW each  imaginary part of slot K.
- out_valid  output  1  out_re/out_im/out_idx/out_last valid.
- out_ready  input  1  consumer accepts current sample.
- out_re  output  DW  real part of current sample, scaled.
- out_im  output  DW  imaginary part of current sample, scaled.
- out_idx  output  4  output index k of current sample (0..15).
- out_last  output  1  high with k=15.
- busy  output  1  frame held and not fully drained.

Behaviour:
- Reset (async assert, sync release): state IDLE, buffer cleared to 0, counter k=0; out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, busy=0. in_ready=1 from reset onward (state IDLE).
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture all 32 inputs into the buffer, set k=0, go to SEND.
  - SEND: out_valid=1, busy=1. The outputs combinationally select buffer slot (BITREV ? bitrev4(k) : k).
- Accept rule: a sample is consumed on a cycle with out_valid&out_ready; k increments on that cycle.
- Last sample: consuming k=15 ends the frame. If in_valid is also high that cycle, the next frame is captured in the same cycle (in_ready = IDLE | (SEND & k==15 & out_ready)), k returns to 0, and the block stays in SEND with no bubble. Otherwise it goes to IDLE.
- Stall: out_valid high with out_ready low holds k, out_re, out_im, out_idx and out_last stable. in_ready stays 0 during any SEND cycle that does not consume k=15. The buffer never changes mid-frame.
- Latency: a frame captured at edge T presents k=0 from after edge T until consumed. The minimum frame period is 16 cycles with out_ready tied high.
- out_last = SEND & (k==15). out_idx = k, always natural order even when BITREV=1.
- Scaling: for SHIFT>0, out = (x + 2^(SHIFT-1)) >>> SHIFT, computed at DW+1 bits and truncated to DW. The result always fits because SHIFT>=1 halves the range. SHIFT=0 passes the value through unchanged.
- in_valid while in_ready=0: ignored and not captured. Upstream holds its data.
- Reset mid-frame: the frame is dropped, outputs return to reset values at once, and no partial-frame marker is produced.
- X on the data inputs while in_valid=0 must not propagate into the buffer.

Test Plan:
- Reset, then slot K = {R=K, I=-K}, in_valid pulse, out_ready=1, BITREV=0, SHIFT=0 -> 16 consecutive beats with out_re=0..15, out_im=0,-1(17'h1FFFF),...,-15, out_last only on beat 15, then out_valid=0 and in_ready=1.
- Same frame, BITREV=1 -> out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; out_idx 0..15.
- SHIFT=1, slots R = 3, -3 (17'h1FFFD), 17'h0FFFF, 17'h10000 -> out_re = 2, 17'h1FFFF, 17'h08000, 17'h18000.
- out_ready toggles 1,0,0,1,... -> no sample duplicated or skipped, outputs stable while stalled, in_ready=0 throughout.
- Second frame held on in_valid from beat 10, out_ready=1 -> captured on the beat-15 cycle; next cycle shows the new frame's k=0 (no bubble), exactly 32 beats total.
- rst_n low at beat 7 -> out_valid=0, busy=0 immediately. After release, in_ready=1 and the next frame starts at k=0 with correct data.

Source files
------------

// File: rtl/fft_out_serializer.sv
// fft_out_serializer
// Takes one full 16-point complex frame in parallel from the final butterfly
// stage and streams it out one sample per cycle under valid/ready. Samples can
// be read in natural or bit-reversed slot order. An optional rounded
// arithmetic down-shift is applied on the way out. When the last sample of a
// frame is consumed, a waiting frame is captured on that same cycle, so
// back-to-back frames stream with no bubble between them.

module fft_out_serializer #(
    parameter int DW     = 17,
    parameter int BITREV = 0,
    parameter int SHIFT  = 0
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_i0_R,
    input  logic [DW-1:0] data_i0_I,
    input  logic [DW-1:0] data_i1_R,
    input  logic [DW-1:0] data_i1_I,
    input  logic [DW-1:0] data_i2_R,
    input  logic [DW-1:0] data_i2_I,
    input  logic [DW-1:0] data_i3_R,
    input  logic [DW-1:0] data_i3_I,
    input  logic [DW-1:0] data_i4_R,
    input  logic [DW-1:0] data_i4_I,
    input  logic [DW-1:0] data_i5_R,
    input  logic [DW-1:0] data_i5_I,
    input  logic [DW-1:0] data_i6_R,
    input  logic [DW-1:0] data_i6_I,
    input  logic [DW-1:0] data_i7_R,
    input  logic [DW-1:0] data_i7_I,
    input  logic [DW-1:0] data_i8_R,
    input  logic [DW-1:0] data_i8_I,
    input  logic [DW-1:0] data_i9_R,
    input  logic [DW-1:0] data_i9_I,
    input  logic [DW-1:0] data_i10_R,
    input  logic [DW-1:0] data_i10_I,
    input  logic [DW-1:0] data_i11_R,
    input  logic [DW-1:0] data_i11_I,
    input  logic [DW-1:0] data_i12_R,
    input  logic [DW-1:0] data_i12_I,
    input  logic [DW-1:0] data_i13_R,
    input  logic [DW-1:0] data_i13_I,
    input  logic [DW-1:0] data_i14_R,
    input  logic [DW-1:0] data_i14_I,
    input  logic [DW-1:0] data_i15_R,
    input  logic [DW-1:0] data_i15_I,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [3:0]    out_idx,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    k;
    logic [3:0]    k_next;
    logic          capture;

    logic [DW-1:0] in_re  [16];
    logic [DW-1:0] in_im  [16];
    logic [DW-1:0] buf_re [16];
    logic [DW-1:0] buf_im [16];

    logic [3:0]    rd_slot;
    logic [DW-1:0] sel_re;
    logic [DW-1:0] sel_im;
    logic [DW-1:0] scl_re;
    logic [DW-1:0] scl_im;

    // Reverse the four bits of a sample index (radix-2 output ordering).
    function automatic logic [3:0] bitrev4(input logic [3:0] s);
        return {s[0], s[1], s[2], s[3]};
    endfunction

    // Gather the flat per-slot ports into arrays so the rest of the block can loop.
    assign in_re[0]  = data_i0_R;
    assign in_im[0]  = data_i0_I;
    assign in_re[1]  = data_i1_R;
    assign in_im[1]  = data_i1_I;
    assign in_re[2]  = data_i2_R;
    assign in_im[2]  = data_i2_I;
    assign in_re[3]  = data_i3_R;
    assign in_im[3]  = data_i3_I;
    assign in_re[4]  = data_i4_R;
    assign in_im[4]  = data_i4_I;
    assign in_re[5]  = data_i5_R;
    assign in_im[5]  = data_i5_I;
    assign in_re[6]  = data_i6_R;
    assign in_im[6]  = data_i6_I;
    assign in_re[7]  = data_i7_R;
    assign in_im[7]  = data_i7_I;
    assign in_re[8]  = data_i8_R;
    assign in_im[8]  = data_i8_I;
    assign in_re[9]  = data_i9_R;
    assign in_im[9]  = data_i9_I;
    assign in_re[10] = data_i10_R;
    assign in_im[10] = data_i10_I;
    assign in_re[11] = data_i11_R;
    assign in_im[11] = data_i11_I;
    assign in_re[12] = data_i12_R;
    assign in_im[12] = data_i12_I;
    assign in_re[13] = data_i13_R;
    assign in_im[13] = data_i13_I;
    assign in_re[14] = data_i14_R;
    assign in_im[14] = data_i14_I;
    assign in_re[15] = data_i15_R;
    assign in_im[15] = data_i15_I;

    // Next-state and handshake logic: ready opens in IDLE, or on the cycle the last sample leaves.
    always_comb begin
        state_next = state;
        k_next     = k;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture    = 1'b1;
                    k_next     = 4'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    k_next = k + 4'd1;
                    if (k == 4'd15) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                k_next     = 4'd0;
            end
        endcase
    end

    // State and sample counter; reset drops any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    // Frame buffer; written only on a handshake so idle-time garbage never lands in it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < 16; i++) begin
                buf_re[i] <= in_re[i];
                buf_im[i] <= in_im[i];
            end
        end
    end

    assign rd_slot = (BITREV != 0) ? bitrev4(k) : k;
    assign sel_re  = buf_re[rd_slot];
    assign sel_im  = buf_im[rd_slot];

    // Rounded down-scaling: add half an output LSB one bit wider, then shift arithmetically.
    generate
        if (SHIFT == 0) begin : g_pass
            assign scl_re = sel_re;
            assign scl_im = sel_im;
        end else begin : g_round
            localparam logic signed [DW:0] HALF = (DW+1)'(2 ** (SHIFT - 1));
            logic signed [DW:0] ext_re;
            logic signed [DW:0] ext_im;
            assign ext_re = $signed({sel_re[DW-1], sel_re}) + HALF;
            assign ext_im = $signed({sel_im[DW-1], sel_im}) + HALF;
            assign scl_re = DW'(ext_re >>> SHIFT);
            assign scl_im = DW'(ext_im >>> SHIFT);
        end
    endgenerate

    assign out_re   = out_valid ? scl_re : '0;
    assign out_im   = out_valid ? scl_im : '0;
    assign out_idx  = out_valid ? k : 4'd0;
    assign out_last = out_valid && (k == 4'd15);

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer
// Three copies of the serializer (natural order, bit-reversed, SHIFT=1) are
// driven with identical stimulus. A queue of pending beats stands in for the
// block: capture appends a frame's 16 beats, each accepted beat pops one, and
// every output of every copy is compared against the head of that queue.

module tb_fft_out_serializer;

    localparam int DW = 17;

    typedef struct {
        int            k;
        logic [DW-1:0] re_nat;
        logic [DW-1:0] im_nat;
        logic [DW-1:0] re_rev;
        logic [DW-1:0] im_rev;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] d_re [16];
    logic [DW-1:0] d_im [16];
    logic [DW-1:0] fr_re [16];
    logic [DW-1:0] fr_im [16];

    logic          ir  [3];
    logic          ov  [3];
    logic          ol  [3];
    logic          bz  [3];
    logic [DW-1:0] ore [3];
    logic [DW-1:0] oim [3];
    logic [3:0]    oidx [3];

    beat_t q[$];
    int    total = 0;
    int    bad = 0;
    int    beatCount = 0;
    logic  chkRev = 1'b0;
    logic  chkShift = 1'b0;
    int    revTab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    logic [DW-1:0] shiftTab [4] = '{17'h00002, 17'h1FFFF, 17'h08000, 17'h18000};

    always #5 clk = ~clk;

    fft_out_serializer #(.DW(DW), .BITREV(0), .SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .data_i0_R(d_re[0]),   .data_i0_I(d_im[0]),   .data_i1_R(d_re[1]),   .data_i1_I(d_im[1]),
        .data_i2_R(d_re[2]),   .data_i2_I(d_im[2]),   .data_i3_R(d_re[3]),   .data_i3_I(d_im[3]),
        .data_i4_R(d_re[4]),   .data_i4_I(d_im[4]),   .data_i5_R(d_re[5]),   .data_i5_I(d_im[5]),
        .data_i6_R(d_re[6]),   .data_i6_I(d_im[6]),   .data_i7_R(d_re[7]),   .data_i7_I(d_im[7]),
        .data_i8_R(d_re[8]),   .data_i8_I(d_im[8]),   .data_i9_R(d_re[9]),   .data_i9_I(d_im[9]),
        .data_i10_R(d_re[10]), .data_i10_I(d_im[10]), .data_i11_R(d_re[11]), .data_i11_I(d_im[11]),
        .data_i12_R(d_re[12]), .data_i12_I(d_im[12]), .data_i13_R(d_re[13]), .data_i13_I(d_im[13]),
        .data_i14_R(d_re[14]), .data_i14_I(d_im[14]), .data_i15_R(d_re[15]), .data_i15_I(d_im[15]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_re(ore[0]), .out_im(oim[0]),
        .out_idx(oidx[0]), .out_last(ol[0]), .busy(bz[0])
    );

    fft_out_serializer #(.DW(DW), .BITREV(1), .SHIFT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .data_i0_R(d_re[0]),   .data_i0_I(d_im[0]),   .data_i1_R(d_re[1]),   .data_i1_I(d_im[1]),
        .data_i2_R(d_re[2]),   .data_i2_I(d_im[2]),   .data_i3_R(d_re[3]),   .data_i3_I(d_im[3]),
        .data_i4_R(d_re[4]),   .data_i4_I(d_im[4]),   .data_i5_R(d_re[5]),   .data_i5_I(d_im[5]),
        .data_i6_R(d_re[6]),   .data_i6_I(d_im[6]),   .data_i7_R(d_re[7]),   .data_i7_I(d_im[7]),
        .data_i8_R(d_re[8]),   .data_i8_I(d_im[8]),   .data_i9_R(d_re[9]),   .data_i9_I(d_im[9]),
        .data_i10_R(d_re[10]), .data_i10_I(d_im[10]), .data_i11_R(d_re[11]), .data_i11_I(d_im[11]),
        .data_i12_R(d_re[12]), .data_i12_I(d_im[12]), .data_i13_R(d_re[13]), .data_i13_I(d_im[13]),
        .data_i14_R(d_re[14]), .data_i14_I(d_im[14]), .data_i15_R(d_re[15]), .data_i15_I(d_im[15]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_re(ore[1]), .out_im(oim[1]),
        .out_idx(oidx[1]), .out_last(ol[1]), .busy(bz[1])
    );

    fft_out_serializer #(.DW(DW), .BITREV(0), .SHIFT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .data_i0_R(d_re[0]),   .data_i0_I(d_im[0]),   .data_i1_R(d_re[1]),   .data_i1_I(d_im[1]),
        .data_i2_R(d_re[2]),   .data_i2_I(d_im[2]),   .data_i3_R(d_re[3]),   .data_i3_I(d_im[3]),
        .data_i4_R(d_re[4]),   .data_i4_I(d_im[4]),   .data_i5_R(d_re[5]),   .data_i5_I(d_im[5]),
        .data_i6_R(d_re[6]),   .data_i6_I(d_im[6]),   .data_i7_R(d_re[7]),   .data_i7_I(d_im[7]),
        .data_i8_R(d_re[8]),   .data_i8_I(d_im[8]),   .data_i9_R(d_re[9]),   .data_i9_I(d_im[9]),
        .data_i10_R(d_re[10]), .data_i10_I(d_im[10]), .data_i11_R(d_re[11]), .data_i11_I(d_im[11]),
        .data_i12_R(d_re[12]), .data_i12_I(d_im[12]), .data_i13_R(d_re[13]), .data_i13_I(d_im[13]),
        .data_i14_R(d_re[14]), .data_i14_I(d_im[14]), .data_i15_R(d_re[15]), .data_i15_I(d_im[15]),
        .out_valid(ov[2]), .out_ready(out_ready), .out_re(ore[2]), .out_im(oim[2]),
        .out_idx(oidx[2]), .out_last(ol[2]), .busy(bz[2])
    );

    // Index k with its four bits mirrored, built bit by bit.
    function automatic int refBitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r = r + (1 << (3 - b));
        end
        return r;
    endfunction

    // Round-half-up division by 2^s done on plain integers.
    function automatic logic [DW-1:0] scaleRef(input logic [DW-1:0] x, input int s);
        int v;
        v = int'($signed(x));
        if (s > 0) v = (v + (1 << (s - 1))) >>> s;
        return v[DW-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic driveIdleData();
        for (int i = 0; i < 16; i++) begin
            d_re[i] = 'x;
            d_im[i] = 'x;
        end
    endtask

    // Present the frame held in fr_re/fr_im and raise in_valid until the model captures it.
    task automatic applyStimulus();
        for (int i = 0; i < 16; i++) begin
            d_re[i] = fr_re[i];
            d_im[i] = fr_im[i];
        end
        in_valid = 1'b1;
    endtask

    task automatic fillRandomFrame();
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = DW'($urandom);
            fr_im[i] = DW'($urandom);
        end
    endtask

    task automatic pushFrame();
        beat_t b;
        for (int k = 0; k < 16; k++) begin
            b.k      = k;
            b.re_nat = d_re[k];
            b.im_nat = d_im[k];
            b.re_rev = d_re[refBitrev(k)];
            b.im_rev = d_im[refBitrev(k)];
            q.push_back(b);
        end
    endtask

    task automatic checkAll();
        logic          ev;
        logic          el;
        logic [3:0]    ek;
        logic [DW-1:0] er;
        logic [DW-1:0] ei;
        logic          eir;
        eir = (q.size() == 0) || (q.size() == 1 && out_ready);
        for (int d = 0; d < 3; d++) begin
            ev = (q.size() > 0);
            el = 1'b0;
            ek = 4'd0;
            er = '0;
            ei = '0;
            if (ev) begin
                ek = 4'(q[0].k);
                el = (q[0].k == 15);
                if (d == 0) begin
                    er = q[0].re_nat;
                    ei = q[0].im_nat;
                end else if (d == 1) begin
                    er = q[0].re_rev;
                    ei = q[0].im_rev;
                end else begin
                    er = scaleRef(q[0].re_nat, 1);
                    ei = scaleRef(q[0].im_nat, 1);
                end
            end
            checkOutput($sformatf("dut%0d.out_valid", d), 32'(ov[d]), 32'(ev));
            checkOutput($sformatf("dut%0d.busy", d), 32'(bz[d]), 32'(ev));
            checkOutput($sformatf("dut%0d.in_ready", d), 32'(ir[d]), 32'(eir));
            checkOutput($sformatf("dut%0d.out_re", d), 32'(ore[d]), 32'(er));
            checkOutput($sformatf("dut%0d.out_im", d), 32'(oim[d]), 32'(ei));
            checkOutput($sformatf("dut%0d.out_idx", d), 32'(oidx[d]), 32'(ek));
            checkOutput($sformatf("dut%0d.out_last", d), 32'(ol[d]), 32'(el));
        end
        if (chkRev && q.size() > 0)
            checkOutput("rev_table", 32'(ore[1]), 32'(revTab[q[0].k]));
        if (chkShift && q.size() > 0 && q[0].k < 4)
            checkOutput("shift_table", 32'(ore[2]), 32'(shiftTab[q[0].k]));
    endtask

    // One clock: set out_ready, check at negedge+1, then advance the model across the posedge.
    task automatic runCycle(input logic rdy);
        logic cap;
        logic modelReady;
        out_ready = rdy;
        #1;
        checkAll();
        if (ov[0] && out_ready) beatCount++;
        modelReady = (q.size() == 0) || (q.size() == 1 && out_ready);
        cap = in_valid && modelReady && rst_n;
        @(posedge clk);
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (cap) pushFrame();
        @(negedge clk);
        if (cap) begin
            in_valid = 1'b0;
            driveIdleData();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        driveIdleData();
        @(negedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) runCycle(1'b1);

        $display("[TB] natural and bit-reversed ramp frame");
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = DW'(i);
            fr_im[i] = DW'(-i);
        end
        applyStimulus();
        chkRev = 1'b1;
        repeat (19) runCycle(1'b1);
        chkRev = 1'b0;

        $display("[TB] rounding frame");
        fillRandomFrame();
        fr_re[0] = 17'h00003;
        fr_re[1] = 17'h1FFFD;
        fr_re[2] = 17'h0FFFF;
        fr_re[3] = 17'h10000;
        applyStimulus();
        chkShift = 1'b1;
        repeat (19) runCycle(1'b1);
        chkShift = 1'b0;

        $display("[TB] stalling consumer");
        fillRandomFrame();
        applyStimulus();
        for (int i = 0; i < 52; i++) runCycle((i % 3) == 0);
        repeat (3) runCycle(1'b1);

        $display("[TB] back-to-back frames");
        fillRandomFrame();
        applyStimulus();
        beatCount = 0;
        runCycle(1'b1);
        repeat (10) runCycle(1'b1);
        fillRandomFrame();
        applyStimulus();
        repeat (22) runCycle(1'b1);
        repeat (3) runCycle(1'b1);
        checkOutput("beat_count", 32'(beatCount), 32'd32);

        $display("[TB] reset mid-frame");
        fillRandomFrame();
        applyStimulus();
        repeat (8) runCycle(1'b1);
        rst_n = 1'b0;
        #1;
        q.delete();
        checkOutput("rst.out_valid", 32'(ov[0]), 32'd0);
        checkOutput("rst.busy", 32'(bz[0]), 32'd0);
        checkAll();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runCycle(1'b0);
        checkOutput("rst.in_ready", 32'(ir[0]), 32'd1);
        fillRandomFrame();
        applyStimulus();
        repeat (20) runCycle(1'b1);

        $display("[TB] random frames and random backpressure");
        for (int f = 0; f < 4; f++) begin
            fillRandomFrame();
            applyStimulus();
            repeat (30) runCycle($urandom_range(0, 3) != 0);
        end
        repeat (60) runCycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
